regfile_multiport: RTL

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport.sv | 84 ++++++++
 1 files changed

// File: rtl/regfile_multiport.sv
// Two-read / two-write register file. A clear sweep runs after reset, and
// `define REGFILE_BYPASS_EN adds write-to-read forwarding.
module regfile_multiport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic [WIDTH-1:0]  Data1,
  output logic [WIDTH-1:0]  Data2,
  input  logic [ADDR_W-1:0] RD,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RD2,
  input  logic [WIDTH-1:0]  WriteData2,
  input  logic              RegWrite2,
  output logic              ready
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic ZR = (ZERO_REG != 0);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [WIDTH-1:0]  rf [DEPTH];
  logic              run;
  logic              we_a;
  logic              we_b;

  assign run   = (state == S_RUN) && !reset;
  assign we_a  = run && RegWrite && !(ZR && RD == '0);
  assign we_b  = run && RegWrite2 && !(ZR && RD2 == '0);
  assign ready = (state == S_RUN);

  // Sweep control: restart at address 0 on reset, enter RUN after the last clear
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
    end else if (state == S_CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == LAST) state <= S_RUN;
    end
  end

  // Storage: clear sweep in CLEAR, port B applied last so it wins a collision
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == S_CLEAR) begin
        rf[clr_ptr] <= '0;
      end else begin
        if (we_a) rf[RD] <= WriteData;
        if (we_b) rf[RD2] <= WriteData2;
      end
    end
  end

  // Read port 1: stored value, optional forwarding, forced 0 when not running
  always_comb begin
    Data1 = rf[Read1];
`ifdef REGFILE_BYPASS_EN
    if (we_a && RD == Read1) Data1 = WriteData;
    if (we_b && RD2 == Read1) Data1 = WriteData2;
`endif
    if (!run || (ZR && Read1 == '0)) Data1 = '0;
  end

  // Read port 2: same structure as port 1
  always_comb begin
    Data2 = rf[Read2];
`ifdef REGFILE_BYPASS_EN
    if (we_a && RD == Read2) Data2 = WriteData;
    if (we_b && RD2 == Read2) Data2 = WriteData2;
`endif
    if (!run || (ZR && Read2 == '0)) Data2 = '0;
  end

endmodule
